// File: rtl/reg_file_multiport.sv
// Multiport register file: N_RD registered read ports, two prioritised write ports, optional hardwired r0.
// Define REGFILE_WRBYPASS_EN for write-first forwarding; the default is read-before-write.
module reg_file_multiport #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int N_RD        = 2,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_valid,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     wr_conflict
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              sameAddr;
    logic              writeA;
    logic              writeB;
    logic [ADDR_W-1:0] readAddr [N_RD];
    logic [DATA_W-1:0] readWord [N_RD];

    // Port B (load) beats port A on a shared address; r0 writes are dropped when hardwired.
    always_comb begin
        sameAddr = wa_en && wb_en && (wa_addr == wb_addr);
        writeA   = wa_en && !sameAddr && !((ZERO_REG_EN != 0) && (wa_addr == '0));
        writeB   = wb_en && !((ZERO_REG_EN != 0) && (wb_addr == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else begin
            if (writeA) begin
                mem[wa_addr] <= wa_data;
            end
            if (writeB) begin
                mem[wb_addr] <= wb_data;
            end
        end
    end

    // Value each read port captures at this edge, with optional forwarding of the winning write.
    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            readAddr[i] = rd_addr[i*ADDR_W +: ADDR_W];
            readWord[i] = mem[readAddr[i]];
`ifdef REGFILE_WRBYPASS_EN
            if (writeB && (wb_addr == readAddr[i])) begin
                readWord[i] = wb_data;
            end else if (writeA && (wa_addr == readAddr[i])) begin
                readWord[i] = wa_data;
            end
`endif
            if ((ZERO_REG_EN != 0) && (readAddr[i] == '0)) begin
                readWord[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data     <= '0;
            rd_valid    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int i = 0; i < N_RD; i++) begin
                rd_valid[i] <= rd_en[i];
                if (rd_en[i]) begin
                    rd_data[i*DATA_W +: DATA_W] <= readWord[i];
                end
            end
            wr_conflict <= sameAddr;
        end
    end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Randomised and directed bench for reg_file_multiport; a per-edge scoreboard queue feeds a negedge monitor.
module tb_reg_file_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wr_conflict;

    typedef struct {
        logic [1:0]  valid;
        logic        conflict;
        logic [31:0] data0;
        logic [31:0] data1;
    } expRec_t;

    expRec_t     expQ[$];
    logic [31:0] modelMem [32];
    logic [31:0] holdData [2];
    int          checkCount = 0;
    int          passCount  = 0;

    reg_file_multiport dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle, then advance the reference model at the edge and queue what the DUT should show.
    task automatic applyStimulus(input logic rst, input logic [1:0] ren, input logic [4:0] ra0,
                                 input logic [4:0] ra1, input logic aEn, input logic [4:0] aAddr,
                                 input logic [31:0] aData, input logic bEn, input logic [4:0] bAddr,
                                 input logic [31:0] bData);
        logic [31:0] newMem [32];
        logic [4:0]  ra [2];
        expRec_t     rec;
        reset = rst; rd_en = ren; rd_addr = {ra1, ra0};
        wa_en = aEn; wa_addr = aAddr; wa_data = aData;
        wb_en = bEn; wb_addr = bAddr; wb_data = bData;
        ra[0] = ra0; ra[1] = ra1;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) modelMem[k] = 32'h0;
            holdData[0] = 32'h0; holdData[1] = 32'h0;
            rec.valid = 2'b00; rec.conflict = 1'b0;
        end else begin
            newMem = modelMem;
            if (aEn) newMem[aAddr] = aData;
            if (bEn) newMem[bAddr] = bData;
            newMem[0] = 32'h0;
            for (int p = 0; p < 2; p++) begin
                if (ren[p]) begin
`ifdef REGFILE_WRBYPASS_EN
                    holdData[p] = newMem[ra[p]];
`else
                    holdData[p] = modelMem[ra[p]];
`endif
                end
            end
            modelMem = newMem;
            rec.valid = ren;
            rec.conflict = aEn && bEn && (aAddr == bAddr);
        end
        rec.data0 = holdData[0];
        rec.data1 = holdData[1];
        expQ.push_back(rec);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        expRec_t rec;
        if (expQ.size() > 0) begin
            rec = expQ.pop_front();
            checkOutput("rd_valid", {30'b0, rd_valid}, {30'b0, rec.valid});
            checkOutput("wr_conflict", {31'b0, wr_conflict}, {31'b0, rec.conflict});
            checkOutput("rd_data0", rd_data[31:0], rec.data0);
            checkOutput("rd_data1", rd_data[63:32], rec.data1);
        end
    end

    initial begin
        applyStimulus(1, 2'b11, 1, 2, 1, 3, 32'h1, 1, 4, 32'h2);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset clears a freshly written register
        applyStimulus(0, 2'b00, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0);
        // Dual write then dual read
        applyStimulus(0, 2'b00, 0, 0, 1, 3, 32'h12345678, 1, 7, 32'hCAFEF00D);
        applyStimulus(0, 2'b11, 3, 7, 0, 0, 0, 0, 0, 0);
        // Collision on r9, then on r0
        applyStimulus(0, 2'b00, 0, 0, 1, 9, 32'h1111, 1, 9, 32'h2222);
        applyStimulus(0, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF);
        applyStimulus(0, 2'b11, 0, 9, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
        applyStimulus(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        // Read-during-write on r4
        applyStimulus(0, 2'b00, 0, 0, 1, 4, 32'hA, 0, 0, 0);
        applyStimulus(0, 2'b11, 4, 4, 1, 4, 32'hB, 0, 0, 0);
        applyStimulus(0, 2'b10, 0, 4, 0, 0, 0, 0, 0, 0);
        // Outputs hold while reads are disabled
        idle(3);
        // Reset beats a concurrent write
        applyStimulus(1, 2'b00, 0, 0, 1, 2, 32'h55, 0, 0, 0);
        applyStimulus(0, 2'b01, 2, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(2);
        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
        if (expQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
